// File: rtl/imem_refill_responder_pkg.sv
// Shared constants, FSM encoding and byte-assembly helper for the instruction-memory
// refill responder.
package imem_refill_responder_pkg;

  localparam int unsigned LINE_BYTES     = 64;
  localparam int unsigned WORDS_PER_LINE = 16;
  localparam int unsigned LINE_ADDR_W    = 26;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StBurst = 2'd2
  } state_e;

  // Little-endian: b0 is the byte at the lowest address.
  function automatic logic [31:0] le_word(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/imem_byte_store.sv
// Byte-addressed backing store: one combinational 32-bit read port, one clocked 32-bit
// write port. Contents are never reset.
module imem_byte_store #(
  parameter int unsigned MEM_BYTES = 65536,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);
  import imem_refill_responder_pkg::*;

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr]                  <= wr_data[7:0];
      mem[wr_addr + ADDR_W'(1)]     <= wr_data[15:8];
      mem[wr_addr + ADDR_W'(2)]     <= wr_data[23:16];
      mem[wr_addr + ADDR_W'(3)]     <= wr_data[31:24];
    end
  end

  assign rd_data = le_word(mem[rd_addr], mem[rd_addr + ADDR_W'(1)],
                           mem[rd_addr + ADDR_W'(2)], mem[rd_addr + ADDR_W'(3)]);

endmodule

// File: rtl/imem_refill_responder.sv
// Memory-side responder for I-cache line refills: accepts one line request, waits LATENCY
// cycles, then streams the 16 words of the line with backpressure.
module imem_refill_responder #(
  parameter int unsigned MEM_BYTES      = 65536,
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned WORDS_PER_LINE = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [25:0] req_line_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [3:0]  resp_word_idx,
  output logic        resp_last,
  output logic        resp_error,
  input  logic        prog_we,
  output logic        prog_ready,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);
  import imem_refill_responder_pkg::*;

  localparam int unsigned AW      = $clog2(MEM_BYTES);
  localparam logic [3:0]  LAT_CNT = 4'(LATENCY);
  localparam logic [32:0] MEM_END = 33'(MEM_BYTES);

  if (WORDS_PER_LINE != imem_refill_responder_pkg::WORDS_PER_LINE) begin : g_bad_wpl
    $error("WORDS_PER_LINE must be 16");
  end
  if (LATENCY > 15) begin : g_bad_lat
    $error("LATENCY must be in 0..15");
  end
  if ((MEM_BYTES % LINE_BYTES) != 0 || MEM_BYTES == 0) begin : g_bad_mem
    $error("MEM_BYTES must be a non-zero multiple of 64");
  end

  state_e      state_q;
  logic        req_ready_q, prog_ready_q;
  logic [31:0] base_q;
  logic        line_err_q;
  logic [3:0]  lat_cnt_q;
  logic        resp_valid_q, resp_last_q, resp_error_q;
  logic [31:0] resp_data_q;
  logic [3:0]  idx_q;

  logic [32:0]   line_end;
  logic          line_err;
  logic          wr_en;
  logic [3:0]    rd_idx;
  logic [31:0]   beat_addr;
  logic [31:0]   rd_data;
  logic [31:0]   beat_word;
  logic          unused_beat_hi;

  assign line_end = {1'b0, req_line_addr, 6'd0} + 33'd63;
  assign line_err = line_end >= MEM_END;
  assign wr_en    = prog_we & prog_ready_q & (prog_addr < 32'(MEM_BYTES));

  // Read port always points at the word that the next register load will capture.
  assign rd_idx         = (state_q == StBurst) ? idx_q + 4'd1 : 4'd0;
  assign beat_addr      = base_q + {26'd0, rd_idx, 2'b00};
  assign beat_word      = line_err_q ? 32'd0 : rd_data;
  assign unused_beat_hi = ^beat_addr[31:AW];

  imem_byte_store #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (AW)
  ) u_store (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr ({prog_addr[AW-1:2], 2'b00}),
    .wr_data (prog_data),
    .rd_addr (beat_addr[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b0;
      prog_ready_q <= 1'b0;
      base_q       <= '0;
      line_err_q   <= 1'b0;
      lat_cnt_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      idx_q        <= '0;
      resp_last_q  <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          req_ready_q  <= 1'b1;
          prog_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            base_q       <= {req_line_addr, 6'd0};
            line_err_q   <= line_err;
            lat_cnt_q    <= '0;
            req_ready_q  <= 1'b0;
            prog_ready_q <= 1'b0;
            state_q      <= StWait;
          end
        end
        StWait: begin
          if (lat_cnt_q == LAT_CNT) begin
            state_q      <= StBurst;
            resp_valid_q <= 1'b1;
            idx_q        <= '0;
            resp_last_q  <= 1'b0;
            resp_error_q <= line_err_q;
            resp_data_q  <= beat_word;
          end else begin
            lat_cnt_q <= lat_cnt_q + 4'd1;
          end
        end
        StBurst: begin
          if (resp_ready) begin
            if (resp_last_q) begin
              state_q      <= StIdle;
              resp_valid_q <= 1'b0;
              resp_last_q  <= 1'b0;
              resp_error_q <= 1'b0;
              req_ready_q  <= 1'b1;
              prog_ready_q <= 1'b1;
            end else begin
              idx_q       <= idx_q + 4'd1;
              resp_last_q <= (idx_q == 4'd14);
              resp_data_q <= beat_word;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign prog_ready    = prog_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_word_idx = idx_q;
  assign resp_last     = resp_last_q;
  assign resp_error    = resp_error_q;

endmodule

// File: tb/tb_imem_refill_responder.sv
// Directed bench for imem_refill_responder: one instance with LATENCY 4, one with LATENCY 0.
module tb_imem_refill_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        req_valid, req_ready, resp_valid, resp_ready, resp_last, resp_error;
  logic        prog_we, prog_ready;
  logic [25:0] req_line_addr;
  logic [31:0] resp_data, prog_addr, prog_data;
  logic [3:0]  resp_word_idx;

  logic        req_valid0, req_ready0, resp_valid0, resp_ready0, resp_last0, resp_error0;
  logic        prog_we0, prog_ready0;
  logic [31:0] resp_data0;
  logic [3:0]  resp_word_idx0;

  imem_refill_responder #(.MEM_BYTES(65536), .LATENCY(4), .WORDS_PER_LINE(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_line_addr(req_line_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_word_idx(resp_word_idx), .resp_last(resp_last), .resp_error(resp_error),
    .prog_we(prog_we), .prog_ready(prog_ready), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  imem_refill_responder #(.MEM_BYTES(65536), .LATENCY(0), .WORDS_PER_LINE(16)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_line_addr(req_line_addr),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_data(resp_data0),
    .resp_word_idx(resp_word_idx0), .resp_last(resp_last0), .resp_error(resp_error0),
    .prog_we(prog_we0), .prog_ready(prog_ready0), .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Preload pattern: byte at address a holds a[7:0].
  function automatic logic [31:0] pat_word(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  logic [31:0] beat [16];
  int n_xfer, err_cnt, nz_cnt, stable_bad, last_bad, seq_bad, gap_bad;

  // Issue a request on dut and count edges from accept to first valid beat.
  task automatic request(input logic [25:0] line, input string tag);
    int n;
    check({tag, "_req_ready_pre"}, 32'(req_ready), 32'd1);
    req_line_addr = line;
    req_valid     = 1'b1;
    step();
    req_valid = 1'b0;
    check({tag, "_req_ready_post"}, 32'(req_ready), 32'd0);
    n = 0;
    while (!resp_valid && n < 30) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd5);
  endtask

  // Consume a burst on dut, resp_ready following pat[k%4] each cycle.
  task automatic run_burst(input logic [3:0] pat, input bit prog_during, input string tag);
    int k;
    bit prev_hold;
    logic [31:0] prev_data;
    logic [3:0]  prev_idx;
    k = 0; prev_hold = 0; prev_data = '0; prev_idx = '0;
    n_xfer = 0; err_cnt = 0; nz_cnt = 0; stable_bad = 0; last_bad = 0; seq_bad = 0;
    gap_bad = 0;
    if (prog_during) begin
      prog_we = 1'b1; prog_addr = 32'h48; prog_data = 32'h12345678;
      check({tag, "_prog_ready_burst"}, 32'(prog_ready), 32'd0);
    end
    while (n_xfer < 16 && k < 200) begin
      resp_ready = pat[k % 4];
      if (resp_valid) begin
        if (prev_hold && (resp_data !== prev_data || resp_word_idx !== prev_idx)) stable_bad++;
        if (resp_last !== (resp_word_idx == 4'd15)) last_bad++;
        if (resp_ready) begin
          if (resp_word_idx !== 4'(n_xfer)) seq_bad++;
          beat[n_xfer] = resp_data;
          if (resp_error) err_cnt++;
          if (resp_data != 0) nz_cnt++;
          n_xfer++;
        end
        prev_hold = !resp_ready;
        prev_data = resp_data;
        prev_idx  = resp_word_idx;
      end else begin
        gap_bad++;
        prev_hold = 0;
      end
      step();
      k++;
    end
    resp_ready = 1'b0;
    prog_we    = 1'b0;
    check({tag, "_xfers"}, 32'(n_xfer), 32'd16);
    check({tag, "_seq"}, 32'(seq_bad), 32'd0);
    check({tag, "_last_only15"}, 32'(last_bad), 32'd0);
    check({tag, "_gaps"}, 32'(gap_bad), 32'd0);
    check({tag, "_end_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_end_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  int c, n_acc, first_v, last1, nx, rr_bad, l2_bad, n6;
  int acc_c [2];
  logic [31:0] b0 [32];
  bit acc, xf;

  initial begin
    req_valid = 0; resp_ready = 0; prog_we = 0; req_line_addr = '0;
    prog_addr = '0; prog_data = '0;
    req_valid0 = 0; resp_ready0 = 0; prog_we0 = 0;

    #2 reset = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_prog_ready", 32'(prog_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_outs", {resp_data[27:0], resp_word_idx} ^ 32'(resp_last) ^ 32'(resp_error),
          32'd0);
    step();
    step();
    reset = 1'b1;
    step();
    check("rel_req_ready", 32'(req_ready), 32'd1);
    check("rel_prog_ready", 32'(prog_ready), 32'd1);
    check("rel_req_ready0", 32'(req_ready0), 32'd1);

    // Preload both stores, then place program words and an out-of-range write.
    for (int a = 0; a < 256; a += 4) begin
      prog_we = 1'b1; prog_we0 = 1'b1; prog_addr = 32'(a); prog_data = pat_word(a);
      step();
    end
    prog_we0 = 1'b0;
    prog_addr = 32'h0;     prog_data = 32'h02000093; step();
    prog_addr = 32'h4;     prog_data = 32'hFF800113; step();
    prog_addr = 32'h10000; prog_data = 32'hCAFEF00D; step();
    prog_we = 1'b0;

    // Basic refill.
    request(26'd0, "t1");
    run_burst(4'b1111, 1'b0, "t1");
    check("t1_beat0", beat[0], 32'h02000093);
    check("t1_beat1", beat[1], 32'hFF800113);
    check("t1_beat2", beat[2], 32'h0B0A0908);
    check("t1_beat15", beat[15], 32'h3F3E3D3C);
    check("t1_err", 32'(err_cnt), 32'd0);

    // Backpressure 1,0,0,1.
    request(26'd0, "t2");
    run_burst(4'b1001, 1'b0, "t2");
    check("t2_stable", 32'(stable_bad), 32'd0);
    check("t2_beat1", beat[1], 32'hFF800113);
    check("t2_beat7", beat[7], 32'h1F1E1D1C);

    // LATENCY 0, back-to-back requests with req_valid held.
    n_acc = 0; first_v = -1; last1 = -1; nx = 0; rr_bad = 0;
    acc_c[0] = 0; acc_c[1] = 0;
    req_line_addr = 26'd1; req_valid0 = 1'b1; resp_ready0 = 1'b1;
    for (c = 0; c < 200 && nx < 32; c++) begin
      acc = req_valid0 && req_ready0;
      xf  = resp_valid0 && resp_ready0;
      if (resp_valid0 && first_v < 0) first_v = c;
      if (n_acc == 1 && last1 < 0 && req_ready0) rr_bad++;
      if (acc && n_acc < 2) begin
        acc_c[n_acc] = c;
        n_acc++;
      end
      if (xf) begin
        b0[nx] = resp_data0;
        if (resp_last0 && last1 < 0) last1 = c;
        nx++;
      end
      step();
      if (n_acc == 1) req_line_addr = 26'd2;
      if (n_acc == 2) req_valid0 = 1'b0;
    end
    req_valid0 = 1'b0; resp_ready0 = 1'b0;
    check("t3_accepts", 32'(n_acc), 32'd2);
    check("t3_first_beat", 32'(first_v - acc_c[0]), 32'd2);
    check("t3_req_ready_low", 32'(rr_bad), 32'd0);
    check("t3_gap", 32'(acc_c[1] - last1), 32'd1);
    check("t3_xfers", 32'(nx), 32'd32);
    check("t3_l1_beat0", b0[0], 32'h43424140);
    check("t3_l2_beat0", b0[16], 32'h83828180);
    check("t3_l2_beat15", b0[31], 32'hBFBEBDBC);
    l2_bad = 0;
    for (int i = 0; i < 16; i++) if (b0[16 + i] !== pat_word(128 + 4 * i)) l2_bad++;
    check("t3_l2_all", 32'(l2_bad), 32'd0);

    // Out-of-range line.
    request(26'h400, "t4");
    run_burst(4'b1111, 1'b0, "t4");
    check("t4_err_beats", 32'(err_cnt), 32'd16);
    check("t4_zero_data", 32'(nz_cnt), 32'd0);

    // Write and request on the same edge; write during burst is dropped.
    check("t5_prog_ready_idle", 32'(prog_ready), 32'd1);
    prog_we = 1'b1; prog_addr = 32'h44; prog_data = 32'hDEADBEEF;
    req_valid = 1'b1; req_line_addr = 26'd1;
    step();
    prog_we = 1'b0; req_valid = 1'b0;
    check("t5_req_ready_post", 32'(req_ready), 32'd0);
    n6 = 0;
    while (!resp_valid && n6 < 30) begin
      step();
      n6++;
    end
    check("t5_latency", 32'(n6), 32'd5);
    run_burst(4'b1111, 1'b1, "t5");
    check("t5_beat1", beat[1], 32'hDEADBEEF);
    check("t5_beat2", beat[2], 32'h4B4A4948);
    request(26'd1, "t5b");
    run_burst(4'b1111, 1'b0, "t5b");
    check("t5b_beat1", beat[1], 32'hDEADBEEF);
    check("t5b_beat2", beat[2], 32'h4B4A4948);

    // Reset after beat 5 transfers.
    request(26'd0, "t6");
    n6 = 0; c = 0;
    resp_ready = 1'b1;
    while (n6 < 6 && c < 40) begin
      if (resp_valid) n6++;
      step();
      c++;
    end
    check("t6_pre_idx", 32'(resp_word_idx), 32'd6);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(resp_valid), 32'd0);
    check("t6_rst_req_ready", 32'(req_ready), 32'd0);
    check("t6_rst_idx", 32'(resp_word_idx), 32'd0);
    check("t6_rst_data", resp_data, 32'd0);
    step();
    check("t6_hold_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    step();
    check("t6_rel_req_ready", 32'(req_ready), 32'd1);
    n6 = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) n6++;
      step();
    end
    check("t6_no_resume", 32'(n6), 32'd0);
    resp_ready = 1'b0;
    request(26'd0, "t6b");
    run_burst(4'b1111, 1'b0, "t6b");
    check("t6b_beat0", beat[0], 32'h02000093);
    check("t6b_beat1", beat[1], 32'hFF800113);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
